// File: rtl/jtframe_rom_bridge.sv
// rtl/jtframe_rom_bridge.sv - byte-wide CPU ROM reads served from a 2-entry cache of 16-bit SDRAM words
module jtframe_rom_bridge #(
  parameter int AW  = 18,
  parameter int SDW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [AW-1:0]  cpu_addr,
  input  logic           rom_cs,
  input  logic           flush,
  output logic           rom_ok,
  output logic [7:0]     rom_data,
  output logic [AW-2:0]  sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic           sdram_dok,
  input  logic [SDW-1:0] sdram_data
);

  generate
    if (SDW != 16) begin : g_sdw_check
      $error("jtframe_rom_bridge: SDW must be 16");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [1:0]     valid_q, valid_d;
  logic           lru_q, lru_d;
  logic [AW-2:0]  addr_q, addr_d;
  logic           req_q, req_d;
  logic           discard_q, discard_d;
  logic [AW-2:0]  tag_q  [2];
  logic [SDW-1:0] data_q [2];

  logic [AW-2:0]  cpu_word;
  logic           hit0, hit1, hit;
  logic [SDW-1:0] sel_word;
  logic           done, fill;

  assign cpu_word = cpu_addr[AW-1:1];
  assign hit0     = rom_cs && valid_q[0] && (tag_q[0] == cpu_word);
  assign hit1     = rom_cs && valid_q[1] && (tag_q[1] == cpu_word);
  assign hit      = hit0 || hit1;
  assign sel_word = hit0 ? data_q[0] : data_q[1];

  assign rom_ok     = hit;
  assign rom_data   = cpu_addr[0] ? sel_word[15:8] : sel_word[7:0];
  assign sdram_addr = addr_q;
  assign sdram_req  = req_q;

  // A fetch completes on dok in WAIT, or on ack+dok together in REQ
  assign done = ((state_q == ST_REQ) && sdram_ack && sdram_dok) ||
                ((state_q == ST_WAIT) && sdram_dok);
  assign fill = done && !discard_q && !flush;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    req_d     = req_q;
    discard_d = discard_q;
    valid_d   = valid_q;
    lru_d     = lru_q;

    case (state_q)
      ST_IDLE: begin
        if (rom_cs && !hit && !flush) begin
          addr_d  = cpu_word;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = sdram_dok ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (sdram_dok) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (done)                              discard_d = 1'b0;
    else if (flush && state_q != ST_IDLE)  discard_d = 1'b1;

    if (flush)     valid_d = 2'b00;
    else if (fill) valid_d[lru_q] = 1'b1;

    // Entry 0 wins a double match, so the LRU points at 1 whenever entry 0 hits
    if (fill)             lru_d = ~lru_q;
    else if (!done && hit) lru_d = hit0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 2'b00;
      lru_q     <= 1'b0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      lru_q     <= lru_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[lru_q]  <= addr_q;
      data_q[lru_q] <= sdram_data;
    end
  end

endmodule

// File: tb/tb_jtframe_rom_bridge.sv
// tb/tb_jtframe_rom_bridge.sv - directed bench for jtframe_rom_bridge
module tb_jtframe_rom_bridge;

  localparam int AW  = 18;
  localparam int SDW = 16;

  logic           clk;
  logic           rst_n;
  logic [AW-1:0]  cpu_addr;
  logic           rom_cs;
  logic           flush;
  logic           rom_ok;
  logic [7:0]     rom_data;
  logic [AW-2:0]  sdram_addr;
  logic           sdram_req;
  logic           sdram_ack;
  logic           sdram_dok;
  logic [SDW-1:0] sdram_data;

  int checks   = 0;
  int failures = 0;

  jtframe_rom_bridge #(.AW(AW), .SDW(SDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .rom_cs     (rom_cs),
    .flush      (flush),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data),
    .sdram_addr (sdram_addr),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_dok  (sdram_dok),
    .sdram_data (sdram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rom_cs = 1'b0; flush = 1'b0; sdram_ack = 1'b0; sdram_dok = 1'b0;
    sdram_data = '0; cpu_addr = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // SDRAM side: ack after ack_dly cycles, dok dok_dly cycles after ack (0 = same cycle)
  task automatic serve(input int ack_dly, input int dok_dly, input logic [15:0] d);
    repeat (ack_dly) cyc();
    sdram_ack = 1'b1;
    if (dok_dly == 0) begin sdram_dok = 1'b1; sdram_data = d; end
    cyc();
    sdram_ack = 1'b0; sdram_dok = 1'b0;
    if (dok_dly > 0) begin
      repeat (dok_dly - 1) cyc();
      sdram_dok = 1'b1; sdram_data = d;
      cyc();
      sdram_dok = 1'b0;
    end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [15:0] d);
    cpu_addr = a; rom_cs = 1'b1;
    cyc();
    serve(1, 1, d);
  endtask

  task automatic test_reset();
    rom_cs = 1'b1; cpu_addr = 18'h00100; flush = 1'b0;
    sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_data = '0;
    rst_n = 1'b0;
    cyc(); cyc(); #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL reset_rom_ok: got %b want 0", rom_ok); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", sdram_req); end
    checks++; if (sdram_addr !== 17'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", sdram_addr); end
    rst_n = 1'b1; #1;
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL reset_release_req: got %b want 0", sdram_req); end
    cyc(); #1;
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL reset_first_req: got %b want 1", sdram_req); end
    checks++; if (sdram_addr !== 17'h00080) begin failures++; $display("FAIL reset_first_addr: got %h want 00080", sdram_addr); end
  endtask

  task automatic test_cold_miss();
    do_reset();
    cpu_addr = 18'h00124; rom_cs = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL cold_pre_ok: got %b want 0", rom_ok); end
    cyc(); #1;
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL cold_req: got %b want 1", sdram_req); end
    checks++; if (sdram_addr !== 17'h00092) begin failures++; $display("FAIL cold_addr: got %h want 00092", sdram_addr); end
    serve(3, 4, 16'hBEEF); #1;
    checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL cold_ok: got %b want 1", rom_ok); end
    checks++; if (rom_data !== 8'hEF) begin failures++; $display("FAIL cold_data_lo: got %h want EF", rom_data); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL cold_req_done: got %b want 0", sdram_req); end
    cpu_addr = 18'h00125; #1;
    checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL cold_hi_ok: got %b want 1", rom_ok); end
    checks++; if (rom_data !== 8'hBE) begin failures++; $display("FAIL cold_data_hi: got %h want BE", rom_data); end
    cyc(); #1;
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL cold_no_refetch: got %b want 0", sdram_req); end
    rom_cs = 1'b0; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL cold_cs_low: got %b want 0", rom_ok); end
  endtask

  task automatic test_lru();
    do_reset();
    fetch(18'h00200, 16'hA1A0); #1;
    checks++; if (rom_data !== 8'hA0 || rom_ok !== 1'b1) begin failures++; $display("FAIL lru_fill_a: got ok=%b data=%h want ok=1 data=A0", rom_ok, rom_data); end
    fetch(18'h00300, 16'hB1B0); #1;
    checks++; if (rom_data !== 8'hB0 || rom_ok !== 1'b1) begin failures++; $display("FAIL lru_fill_b: got ok=%b data=%h want ok=1 data=B0", rom_ok, rom_data); end
    cpu_addr = 18'h00200; #1;
    checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL lru_hit_a: got %b want 1", rom_ok); end
    cyc();
    fetch(18'h00400, 16'hC1C0); #1;
    checks++; if (rom_data !== 8'hC0 || rom_ok !== 1'b1) begin failures++; $display("FAIL lru_fill_c: got ok=%b data=%h want ok=1 data=C0", rom_ok, rom_data); end
    cpu_addr = 18'h00201; #1;
    checks++; if (rom_data !== 8'hA1 || rom_ok !== 1'b1) begin failures++; $display("FAIL lru_a_kept: got ok=%b data=%h want ok=1 data=A1", rom_ok, rom_data); end
    cpu_addr = 18'h00300; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL lru_b_evicted: got %b want 0", rom_ok); end
    rom_cs = 1'b0;
  endtask

  task automatic test_addr_change_wait();
    do_reset();
    cpu_addr = 18'h00200; rom_cs = 1'b1;
    cyc();
    sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0; #1;
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL chg_req_drop: got %b want 0", sdram_req); end
    cpu_addr = 18'h00400;
    cyc(); cyc(); #1;
    checks++; if (sdram_req !== 1'b0 || rom_ok !== 1'b0) begin failures++; $display("FAIL chg_waiting: got req=%b ok=%b want 0 0", sdram_req, rom_ok); end
    sdram_dok = 1'b1; sdram_data = 16'hA1A0; cyc(); sdram_dok = 1'b0; #1;
    checks++; if (sdram_req !== 1'b0 || rom_ok !== 1'b0) begin failures++; $display("FAIL chg_after_fill: got req=%b ok=%b want 0 0", sdram_req, rom_ok); end
    cyc(); #1;
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL chg_second_req: got %b want 1", sdram_req); end
    checks++; if (sdram_addr !== 17'h00200) begin failures++; $display("FAIL chg_second_addr: got %h want 00200", sdram_addr); end
    cpu_addr = 18'h00200; #1;
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'hA0) begin failures++; $display("FAIL chg_a_filled: got ok=%b data=%h want ok=1 data=A0", rom_ok, rom_data); end
    cpu_addr = 18'h00400;
    serve(1, 1, 16'hC1C0); #1;
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'hC0) begin failures++; $display("FAIL chg_c_filled: got ok=%b data=%h want ok=1 data=C0", rom_ok, rom_data); end
  endtask

  task automatic test_flush();
    do_reset();
    cpu_addr = 18'h00200; rom_cs = 1'b1;
    cyc();
    sdram_ack = 1'b1; cyc(); sdram_ack = 1'b0;
    flush = 1'b1; cyc(); flush = 1'b0;
    cyc();
    sdram_dok = 1'b1; sdram_data = 16'hDEAD; cyc(); sdram_dok = 1'b0; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL flush_no_fill: got %b want 0", rom_ok); end
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL flush_req_idle: got %b want 0", sdram_req); end
    cyc(); #1;
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 17'h00100) begin failures++; $display("FAIL flush_refetch: got req=%b addr=%h want 1 00100", sdram_req, sdram_addr); end
    serve(1, 1, 16'h5678); #1;
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'h78) begin failures++; $display("FAIL flush_refill: got ok=%b data=%h want ok=1 data=78", rom_ok, rom_data); end
    flush = 1'b1; #1;
    checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL flush_hit_same_cycle: got %b want 1", rom_ok); end
    cyc(); #1;
    checks++; if (rom_ok !== 1'b0 || sdram_req !== 1'b0) begin failures++; $display("FAIL flush_deferred: got ok=%b req=%b want 0 0", rom_ok, sdram_req); end
    flush = 1'b0;
    cyc(); #1;
    checks++; if (sdram_req !== 1'b1) begin failures++; $display("FAIL flush_req_after: got %b want 1", sdram_req); end
  endtask

  task automatic test_ack_dok_same();
    do_reset();
    cpu_addr = 18'h02468; rom_cs = 1'b1;
    cyc();
    sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h1234;
    cyc();
    sdram_ack = 1'b0; sdram_dok = 1'b0; #1;
    checks++; if (sdram_req !== 1'b0) begin failures++; $display("FAIL same_req: got %b want 0", sdram_req); end
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'h34) begin failures++; $display("FAIL same_lo: got ok=%b data=%h want ok=1 data=34", rom_ok, rom_data); end
    cpu_addr = 18'h02469; #1;
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'h12) begin failures++; $display("FAIL same_hi: got ok=%b data=%h want ok=1 data=12", rom_ok, rom_data); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    cpu_addr = 18'h00600; rom_cs = 1'b1;
    cyc();
    rst_n = 1'b0; #1;
    checks++; if (sdram_req !== 1'b0 || sdram_addr !== 17'h0) begin failures++; $display("FAIL midrst_async: got req=%b addr=%h want 0 0", sdram_req, sdram_addr); end
    rom_cs = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h9999;
    cyc();
    sdram_ack = 1'b0; sdram_dok = 1'b0;
    rom_cs = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL midrst_late_dok: got %b want 0", rom_ok); end
    cyc(); #1;
    checks++; if (sdram_req !== 1'b1 || sdram_addr !== 17'h00300) begin failures++; $display("FAIL midrst_new_req: got req=%b addr=%h want 1 00300", sdram_req, sdram_addr); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_lru();
    test_addr_change_wait();
    test_flush();
    test_ack_dok_same();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_rom_bridge.md
Name: jtframe_rom_bridge

Overview:
- Sits directly upstream of the CPU wait-state generator.
- Converts CPU byte-wide ROM reads into 16-bit SDRAM word requests, and keeps a 2-entry word cache.
- Produces the rom_cs/rom_ok pair that the wait generator consumes. rom_ok deasserts while a fetch is outstanding, so the CPU clock enable gets gated.

Parameters:
- AW, 18, CPU byte address width (AW>=2).
- SDW, 16, SDRAM data width; fixed at 16; any other value is a configuration error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  AW  CPU byte address
- rom_cs  in  1  CPU ROM chip select
- flush  in  1  invalidate cache (bank switch); single-cycle pulse or level
- rom_ok  out  1  data valid for current cpu_addr
- rom_data  out  8  byte selected by cpu_addr[0] (0 = low byte)
- sdram_addr  out  AW-1  word address of outstanding fetch
- sdram_req  out  1  request, held until acknowledged
- sdram_ack  in  1  SDRAM accepted request
- sdram_dok  in  1  sdram_data valid (one cycle)
- sdram_data  in  SDW  fetched word

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: rom_ok=0, sdram_req=0, sdram_addr=0, both valid bits=0, LRU=0, FSM=IDLE. rom_data is don't-care while rom_ok=0.
- Cache:
  - 2 entries, each {valid, tag[AW-2:0], data[15:0]}.
  - tag is compared against cpu_addr[AW-1:1].
  - hit = rom_cs && entry valid && tag match.
- rom_ok and rom_data are combinational from cpu_addr/rom_cs and cache state. A hit gives zero latency.
  - rom_ok=0 whenever rom_cs=0.
  - If both entries match (cannot happen by construction), entry 0 wins.
- LRU bit names the entry to replace next.
  - On a hit to entry k (in a cycle where a fetch does not complete): LRU <= ~k.
  - On a fill of entry k: LRU <= ~k.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: on rom_cs && !hit && !flush, latch sdram_addr <= cpu_addr[AW-1:1], assert sdram_req next cycle, go to REQ.
  - REQ: sdram_req=1. On sdram_ack, drop sdram_req next cycle.
    - ack && !dok -> WAIT.
    - ack && dok in the same cycle -> fill, then IDLE.
  - WAIT: on sdram_dok, fill, then IDLE.
  - Fill: the entry at LRU gets {1, sdram_addr, sdram_data}.
- Latency:
  - Miss detected in cycle N -> sdram_req high in N+1.
  - Fill on the dok cycle D -> rom_ok=1 at D+1 if the address still matches.
  - Back-to-back: a new miss may be detected in the cycle after the fill (IDLE).
- cpu_addr change or rom_cs drop during REQ/WAIT:
  - The outstanding fetch is never cancelled; it completes and fills normally.
  - The new address is evaluated on return to IDLE.
- flush:
  - Clears both valid bits on the same clock edge.
  - If asserted while in REQ/WAIT, a "discard" flag is set: the returning dok completes the handshake but does not write the cache. The flag clears on that dok.
  - flush and dok in the same cycle: no fill.
  - flush in IDLE with a miss pending: the request is deferred one cycle.
- Only one outstanding request; sdram_req never reasserts before dok is received.
- Asynchronous reset mid-fetch:
  - Returns to the reset values immediately.
  - A late dok arriving after reset is ignored (FSM is in IDLE).
- rom_cs rising on an address that is already cached: rom_ok=1 in the same cycle. The downstream block handles its own rising-edge penalty.

Test Plan:
- Reset: hold rst_n=0 with rom_cs=1 -> rom_ok=0, sdram_req=0. Release -> sdram_req=1 one cycle after the first clock with rom_cs=1.
- Cold miss:
  - Stimulus: cpu_addr=0x00124, ack 3 cycles after req, dok with sdram_data=0xBEEF 4 cycles later.
  - Required: sdram_addr=0x00092; rom_ok=1 and rom_data=0xEF the cycle after dok.
  - Then cpu_addr=0x00125 -> rom_ok=1, rom_data=0xBE in the same cycle, no new sdram_req.
- LRU:
  - Fill word A, then word B; hit A; miss on C.
  - Required: C replaces B; A still hits, B misses.
- Address change in WAIT: move cpu_addr from A to C while waiting.
  - Required: A's fetch fills; second request for C issued in the cycle after the fill's IDLE detection; rom_ok only for C.
- flush during WAIT:
  - Required: dok data is not cached; rom_ok stays 0; a new request for the same word is issued after dok.
- ack and dok in the same cycle with data 0x1234:
  - Required: fill occurs, sdram_req=0 next cycle, rom_ok=1 next cycle, rom_data=0x34 for an even address.
